mont_mul_seq_ctrl: RTL and testbench
====================================

// Module: mont_mul_seq_ctrl
// PURPOSE
//  Sequencer for one digit-serial Montgomery multiplication. Launches the multiple-table
//  precompute (mxn/bxn tables) and waits for its done strobe with a watchdog. Then walks the
//  radix-2^PBITS digit loop MSB-first, issues the final conditional subtraction and signals done.
//  Sits between the host start/abort interface and the precompute + accumulator datapath.
// PARAMETERS
//  NBITS   4096          operand width; NBITS % PBITS == 0 is required
//  PBITS   1             digit width in bits; table size MLSIZE = 1<<PBITS
//  ITERS   NBITS/PBITS   localparam, number of loop iterations; DW = $clog2(ITERS) (min 1)
//  WDOG    MLSIZE+4      precompute watchdog limit in cycles
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst_n         in   1   synchronous active-low reset
//  start         in   1   start request, sampled only in IDLE
//  abort         in   1   cancel the current operation
//  reuse_tables  in   1   skip precompute when tables are valid (macro-gated)
//  mxn_done      in   1   precompute-complete strobe from the table generator
//  mxn_en_p      out  1   one-cycle precompute launch pulse
//  acc_clr       out  1   one-cycle accumulator clear
//  step_en       out  1   loop-step strobe
//  digit_idx     out  DW  digit index of the current step
//  fin_sub_en    out  1   one-cycle final-subtract strobe
//  busy          out  1   operation in progress
//  done          out  1   one-cycle completion pulse
//  err           out  1   sticky watchdog error
// BEHAVIOUR
//  - All outputs are registered. Reset (rst_n=0 at a posedge) applies at that edge:
//    state=IDLE, all outputs=0, tables_valid=0, err=0. A reset mid-operation aborts the
//    operation and produces no done.
//  - FSM states: IDLE, PRECOMP, LOOP, FINSUB, DONE.
//  - IDLE, start=1 and abort=0:
//    - err clears.
//    - Next cycle: busy=1, acc_clr=1, mxn_en_p=1. Go to PRECOMP; watchdog counter = 0.
//  - PRECOMP:
//    - mxn_done is ignored in the cycle mxn_en_p=1.
//    - Later, mxn_done=1 sets tables_valid. Next cycle goes to LOOP.
//    - The watchdog counts the cycles after the mxn_en_p cycle. When it reaches WDOG without
//      mxn_done: next cycle err=1, busy=0, state IDLE, tables_valid=0, no done.
//  - LOOP:
//    - step_en=1 for exactly ITERS consecutive cycles.
//    - digit_idx = ITERS-1 down to 0, one step per cycle.
//  - FINSUB: the cycle after the digit_idx=0 step, fin_sub_en=1 for one cycle.
//  - DONE:
//    - Next cycle: done=1 and busy=0, then back to IDLE.
//    - A start in the DONE cycle is ignored; start is accepted only in IDLE.
//  - Latency: start sampled at edge 0, mxn_done sampled at edge k (k>=2). Steps occupy cycles
//    k+1 .. k+ITERS, fin_sub_en is at k+ITERS+1 and done is at k+ITERS+2.
//  - start while busy: ignored, no queueing.
//  - abort=1 in any non-IDLE state: next cycle all strobes=0, busy=0, state IDLE,
//    tables_valid=0, no done, err unchanged.
//  - abort and start together in IDLE: abort wins and start is dropped.
//  - digit_idx holds its last value while step_en=0, and is 0 after reset.
//  - Watchdog counter width is $clog2(WDOG+1). It saturates and never wraps.
// CONFIGURATION
//  - MXN_TABLE_REUSE_EN defined:
//    - IDLE start with reuse_tables=1 and tables_valid=1 skips PRECOMP.
//    - Next cycle: busy=1, acc_clr=1 and the first step_en (digit_idx=ITERS-1); mxn_en_p stays 0.
//  - MXN_TABLE_REUSE_EN undefined: reuse_tables is ignored and every start precomputes.
//  - The port list is identical in both builds.
// TESTING  (NBITS=8, PBITS=2 -> ITERS=4, MLSIZE=4, WDOG=8; start at edge 0)
//  - Nominal: model returns mxn_done at edge 4.
//    -> mxn_en_p+acc_clr at cyc1; step_en cyc5-8 with idx 3,2,1,0; fin_sub_en cyc9;
//       done cyc10; busy=1 on cyc1-9.
//  - Watchdog: mxn_done held 0 -> err=1 and busy=0 at cyc10, no done.
//    Next start clears err and issues mxn_en_p.
//  - Abort: abort=1 while digit_idx=2 -> next cycle step_en=0, busy=0, no done.
//    Then start with reuse_tables=1 -> mxn_en_p=1 (tables invalidated).
//  - Collisions: start during LOOP -> ignored, single done. start+abort in IDLE -> busy stays 0.
//  - Reuse: with MXN_TABLE_REUSE_EN, after a nominal run, start+reuse_tables=1
//    -> cyc1 acc_clr+step_en idx3, no mxn_en_p, done cyc6. Without the macro -> mxn_en_p at cyc1.
//  - Reset: rst_n=0 mid-PRECOMP after a watchdog error -> next edge all outputs 0, err=0.
//    Next start with reuse_tables=1 precomputes.

Source files
------------

// File: rtl/mont_mul_seq_ctrl.sv
// mont_mul_seq_ctrl: sequencer for one digit-serial Montgomery multiplication.
// Launches the mxn/bxn table precompute, waits for its done strobe under a
// watchdog, walks the radix-2^PBITS digit loop MSB-first, issues the final
// conditional subtraction and pulses done.
// Optional feature macro: MXN_TABLE_REUSE_EN (skip precompute when tables are
// still valid and the host asks for reuse). The port list is the same either way.
module mont_mul_seq_ctrl #(
  parameter int NBITS = 4096,
  parameter int PBITS = 1,
  parameter int WDOG  = (1 << PBITS) + 4,
  localparam int ITERS = NBITS / PBITS,
  localparam int DW    = (ITERS > 1) ? $clog2(ITERS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          reuse_tables,
  input  logic          mxn_done,
  output logic          mxn_en_p,
  output logic          acc_clr,
  output logic          step_en,
  output logic [DW-1:0] digit_idx,
  output logic          fin_sub_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int WW = $clog2(WDOG + 1);

  if (NBITS % PBITS != 0) begin : g_bad_cfg
    $error("NBITS must be a multiple of PBITS");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECOMP = 3'd1,
    LOOP    = 3'd2,
    FINSUB  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [WW-1:0] wd_cnt;
  logic          tables_valid;

`ifdef MXN_TABLE_REUSE_EN
  logic reuse_hit;
  assign reuse_hit = reuse_tables & tables_valid;
`else
  // Reuse is compiled out: the port and the validity flag stay for a uniform
  // interface but nothing decides on them.
  logic unused_reuse;
  assign unused_reuse = reuse_tables & tables_valid;
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      tables_valid <= 1'b0;
      mxn_en_p     <= 1'b0;
      acc_clr      <= 1'b0;
      step_en      <= 1'b0;
      digit_idx    <= '0;
      fin_sub_en   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // single-cycle strobes default low
      mxn_en_p   <= 1'b0;
      acc_clr    <= 1'b0;
      fin_sub_en <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) begin
        // cancel: drop everything, keep err and digit_idx as they are
        state        <= IDLE;
        busy         <= 1'b0;
        step_en      <= 1'b0;
        tables_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              err     <= 1'b0;
              busy    <= 1'b1;
              acc_clr <= 1'b1;
              wd_cnt  <= '0;
`ifdef MXN_TABLE_REUSE_EN
              if (reuse_hit) begin
                state     <= LOOP;
                step_en   <= 1'b1;
                digit_idx <= DW'(ITERS - 1);
              end else begin
                state    <= PRECOMP;
                mxn_en_p <= 1'b1;
              end
`else
              state    <= PRECOMP;
              mxn_en_p <= 1'b1;
`endif
            end
          end
          PRECOMP: begin
            // mxn_done seen in the launch cycle belongs to nothing we asked for
            if (mxn_en_p) begin
              wd_cnt <= '0;
            end else if (mxn_done) begin
              tables_valid <= 1'b1;
              state        <= LOOP;
              step_en      <= 1'b1;
              digit_idx    <= DW'(ITERS - 1);
            end else if (wd_cnt >= WW'(WDOG - 1)) begin
              wd_cnt       <= WW'(WDOG);
              err          <= 1'b1;
              busy         <= 1'b0;
              tables_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + WW'(1);
            end
          end
          LOOP: begin
            if (digit_idx == '0) begin
              step_en    <= 1'b0;
              fin_sub_en <= 1'b1;
              state      <= FINSUB;
            end else begin
              digit_idx <= digit_idx - DW'(1);
            end
          end
          FINSUB: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            step_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mont_mul_seq_ctrl.sv
// Bench for mont_mul_seq_ctrl at NBITS=8, PBITS=2 (ITERS=4, WDOG=8).
// Cycle c of a scenario is the output seen after the c-th driven edge; the
// start of each scenario is sampled on the edge that yields cycle 1.
module tb_mont_mul_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       reuse_tables;
  logic       mxn_done;
  logic       mxn_en_p;
  logic       acc_clr;
  logic       step_en;
  logic [1:0] digit_idx;
  logic       fin_sub_en;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  mont_mul_seq_ctrl #(.NBITS(8), .PBITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .reuse_tables(reuse_tables), .mxn_done(mxn_done),
    .mxn_en_p(mxn_en_p), .acc_clr(acc_clr), .step_en(step_en),
    .digit_idx(digit_idx), .fin_sub_en(fin_sub_en), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mxn_en_p, acc_clr, step_en, digit_idx, fin_sub_en, busy, done, err}
  function automatic logic [8:0] ev(input logic en, input logic clr, input logic stp,
                                    input logic [1:0] idx, input logic fin,
                                    input logic bsy, input logic dn, input logic er);
    return {en, clr, stp, idx, fin, bsy, dn, er};
  endfunction

  function automatic logic [8:0] obs();
    return {mxn_en_p, acc_clr, step_en, digit_idx, fin_sub_en, busy, done, err};
  endfunction

  // Reference timeline of a precomputing run: start -> cycle 1, mxn_done on
  // edge k -> steps k+1..k+4, fin k+5, done k+6, idle after. p = prior digit_idx.
  function automatic logic [8:0] nom_exp(input int c, input int k, input logic [1:0] p);
    if (c == 1)     return ev(1, 1, 0, p, 0, 1, 0, 0);
    if (c <= k)     return ev(0, 0, 0, p, 0, 1, 0, 0);
    if (c <= k + 4) return ev(0, 0, 1, 2'(k + 4 - c), 0, 1, 0, 0);
    if (c == k + 5) return ev(0, 0, 0, 2'd0, 1, 1, 0, 0);
    if (c == k + 6) return ev(0, 0, 0, 2'd0, 0, 0, 1, 0);
    return ev(0, 0, 0, 2'd0, 0, 0, 0, 0);
  endfunction

  // Apply inputs for one edge, then sample on the following falling edge.
  task automatic tick(input logic r, input logic s, input logic a, input logic u,
                      input logic m, output logic [8:0] o);
    rst_n = r; start = s; abort = a; reuse_tables = u; mxn_done = m;
    @(posedge clk);
    @(negedge clk);
    o = obs();
  endtask

  task automatic test_reset();
    logic [8:0] got, e;
    exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
    tick(0, 1, 0, 1, 1, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", got, e);
    end
  endtask

  task automatic test_nominal();
    logic [8:0] got, e;
    for (int c = 1; c <= 11; c++) exp_q.push_back(nom_exp(c, 4, 2'd0));
    for (int c = 1; c <= 11; c++) begin
      // mxn_done in the launch cycle must be ignored
      tick(1, c == 1, 0, 0, (c == 2) || (c == 5), got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL nominal cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [8:0] got, e;
    for (int c = 1; c <= 13; c++) begin
      if (c == 1 || c == 12) exp_q.push_back(ev(1, 1, 0, 2'd0, 0, 1, 0, 0));
      else if (c <= 9)       exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 1, 0, 0));
      else if (c <= 11)      exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 1));
      else                   exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
    end
    for (int c = 1; c <= 13; c++) begin
      tick(1, (c == 1) || (c == 12), c == 13, 0, 0, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL watchdog cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [8:0] got, e;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 6)       exp_q.push_back(nom_exp(c, 4, 2'd0));
      else if (c == 8)  exp_q.push_back(ev(1, 1, 0, 2'd2, 0, 1, 0, 0));
      else              exp_q.push_back(ev(0, 0, 0, 2'd2, 0, 0, 0, 0));
    end
    for (int c = 1; c <= 9; c++) begin
      tick(1, (c == 1) || (c == 8), (c == 7) || (c == 9), c == 8, c == 5, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL abort cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_collision();
    logic [8:0] got, e;
    for (int c = 1; c <= 13; c++) exp_q.push_back(nom_exp(c, 4, 2'd2));
    for (int c = 1; c <= 13; c++) begin
      // start in LOOP, start in the DONE cycle, then start+abort in IDLE
      tick(1, (c == 1) || (c == 6) || (c == 11) || (c == 12), c == 12, 0, c == 5, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL collision cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_reuse();
    logic [8:0] got, e;
    for (int c = 1; c <= 11; c++) begin
`ifdef MXN_TABLE_REUSE_EN
      if (c <= 4)       exp_q.push_back(ev(0, c == 1, 1, 2'(4 - c), 0, 1, 0, 0));
      else if (c == 5)  exp_q.push_back(ev(0, 0, 0, 2'd0, 1, 1, 0, 0));
      else if (c == 6)  exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 1, 0));
      else              exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
`else
      exp_q.push_back(nom_exp(c, 4, 2'd0));
`endif
    end
    for (int c = 1; c <= 11; c++) begin
      tick(1, c == 1, 0, 1, c == 5, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reuse cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got, e;
    for (int c = 1; c <= 24; c++) begin
      if (c == 1 || c == 21 || c == 23) exp_q.push_back(ev(1, 1, 0, 2'd0, 0, 1, 0, 0));
      else if (c <= 9)   exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 1, 0, 0));
      else if (c == 10)  exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 1));
      else if (c == 11)  exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
      else if (c <= 20)  exp_q.push_back(nom_exp(c - 11, 2, 2'd0));
      else               exp_q.push_back(ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
    end
    for (int c = 1; c <= 24; c++) begin
      tick(!((c == 11) || (c == 22)),
           (c == 1) || (c == 12) || (c == 21) || (c == 23),
           c == 24, c == 23, c == 14, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid cyc%0d got=%b exp=%b", c, got, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; reuse_tables = 1'b0; mxn_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_watchdog();
    test_abort();
    test_collision();
    test_reuse();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
